// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Contents: FSM state enum, opcode[6:2] constants, ImmSel/WBSel/access-size
// encodings, ALU select constants, instruction-class enum and two helpers
// that map a class to its write-back select and register-write enable.
package control_pkg;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6,
    TRAP   = 3'd7
  } state_e;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_FENCE  = 5'b00011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_S = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // ALU select is {funct7[5], funct3} for arithmetic; ADD and PASS_B cover the rest.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_NOP
  } cls_e;

  function automatic logic [1:0] wb_sel_of(cls_e c);
    if (c == CLS_LOAD) return WB_MEM;
    if (c == CLS_JAL || c == CLS_JALR) return WB_PC4;
    return WB_ALU;
  endfunction

  function automatic logic writes_rd(cls_e c);
    return (c == CLS_R) || (c == CLS_I) || (c == CLS_LOAD) || (c == CLS_JAL) ||
           (c == CLS_JALR) || (c == CLS_LUI) || (c == CLS_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory-side handshake bundle between the control unit and imem/dmem.
// Handshake: the control unit raises a req and holds it, together with
// MemRW/size/sign, until the memory answers with ack; the transfer happens in
// the cycle where req && ack, and ir_write/mdr_write pulse in that same cycle.
// An ack seen while the matching req is low carries no meaning and is ignored.
// master: control unit (drives req/write/attributes); slave: memory (drives ack).
interface multicycle_control_if;
  logic       imem_req;
  logic       imem_ack;
  logic       ir_write;
  logic       dmem_req;
  logic       dmem_ack;
  logic       mdr_write;
  logic       MemRW;
  logic [1:0] d_mem_access_size;
  logic       dmem_is_signed;

  modport master (
    output imem_req, ir_write, dmem_req, mdr_write, MemRW, d_mem_access_size, dmem_is_signed,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, ir_write, dmem_req, mdr_write, MemRW, d_mem_access_size, dmem_is_signed,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational decoder: operation_key {funct7[5], funct3, opcode[6:2]} to
// instruction class and datapath selects.
// Ports: key_i (9) in; cls_o, imm_sel_o(3), a_sel_o, b_sel_o, alu_sel_o(4),
// br_un_o, size_o(2), signed_o, illegal_o out.
// cls_o is the raw class; the top decides what an illegal key turns into.
module mc_decode
  import control_pkg::*;
(
  input  logic [8:0] key_i,
  output cls_e       cls_o,
  output logic [2:0] imm_sel_o,
  output logic       a_sel_o,
  output logic       b_sel_o,
  output logic [3:0] alu_sel_o,
  output logic       br_un_o,
  output logic [1:0] size_o,
  output logic       signed_o,
  output logic       illegal_o
);
  logic       f7b5;
  logic [2:0] f3;
  logic [4:0] op;

  assign f7b5 = key_i[8];
  assign f3   = key_i[7:5];
  assign op   = key_i[4:0];

  always_comb begin
    cls_o     = CLS_NOP;
    imm_sel_o = IMM_I;
    a_sel_o   = 1'b0;
    b_sel_o   = 1'b0;
    alu_sel_o = ALU_ADD;
    br_un_o   = 1'b0;
    size_o    = SZ_W;
    signed_o  = 1'b0;
    illegal_o = 1'b0;
    case (op)
      OP_R: begin
        cls_o     = CLS_R;
        alu_sel_o = {f7b5, f3};
        // funct7[5] only selects SUB and SRA
        illegal_o = f7b5 && (f3 != 3'b000) && (f3 != 3'b101);
      end
      OP_IMM: begin
        cls_o     = CLS_I;
        b_sel_o   = 1'b1;
        // funct7[5] is an immediate bit except for the shift-right form
        alu_sel_o = {f7b5 && (f3 == 3'b101), f3};
        illegal_o = f7b5 && (f3 == 3'b001);
      end
      OP_LOAD: begin
        cls_o     = CLS_LOAD;
        b_sel_o   = 1'b1;
        size_o    = f3[1:0];
        signed_o  = ~f3[2];
        illegal_o = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OP_STORE: begin
        cls_o     = CLS_STORE;
        imm_sel_o = IMM_S;
        b_sel_o   = 1'b1;
        size_o    = f3[1:0];
        illegal_o = f3[2] || (f3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        cls_o     = CLS_BRANCH;
        imm_sel_o = IMM_B;
        a_sel_o   = 1'b1;
        b_sel_o   = 1'b1;
        br_un_o   = f3[1];
        illegal_o = (f3[2:1] == 2'b01);
      end
      OP_JALR: begin
        cls_o     = CLS_JALR;
        b_sel_o   = 1'b1;
        illegal_o = (f3 != 3'b000);
      end
      OP_JAL: begin
        cls_o     = CLS_JAL;
        imm_sel_o = IMM_J;
        a_sel_o   = 1'b1;
        b_sel_o   = 1'b1;
      end
      OP_LUI: begin
        cls_o     = CLS_LUI;
        imm_sel_o = IMM_U;
        b_sel_o   = 1'b1;
        alu_sel_o = ALU_PASSB;
      end
      OP_AUIPC: begin
        cls_o     = CLS_AUIPC;
        imm_sel_o = IMM_U;
        a_sel_o   = 1'b1;
        b_sel_o   = 1'b1;
      end
      OP_FENCE: cls_o = CLS_NOP;
      default:  illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences BOOT/FETCH/DECODE/EXEC/MEM/WB/ERR,
// handshakes with imem/dmem through multicycle_control_if, gates RegWEn and
// pc_write to the single WB cycle, counts retired instructions and flags a
// memory wait timeout.
// Ports: clk, rst_n (async, active low); operation_key(9), BrEq, BrLT in;
// bus (master modport: imem/dmem req/ack, ir_write, mdr_write, MemRW, size, sign);
// PCSel, pc_write, ImmSel(3), BrUn, ASel, BSel, ALUSel(4), RegWEn, WBSel(2),
// retire, instret(CNT_W), mem_err, state(3, debug) out;
// illegal_instr out only when ILLEGAL_TRAP_EN is defined.
// Macro ILLEGAL_TRAP_EN: illegal keys stop in TRAP instead of retiring as NOP.
module multicycle_control
  import control_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8:0]           operation_key,
  input  logic                 BrEq,
  input  logic                 BrLT,
  multicycle_control_if.master bus,
  output logic                 PCSel,
  output logic                 pc_write,
  output logic [2:0]           ImmSel,
  output logic                 BrUn,
  output logic                 ASel,
  output logic                 BSel,
  output logic [3:0]           ALUSel,
  output logic                 RegWEn,
  output logic [1:0]           WBSel,
  output logic                 retire,
  output logic [CNT_W-1:0]     instret,
  output logic                 mem_err,
  output logic [2:0]           state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_instr
`endif
);
  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_d;
  logic                 taken_q, taken_d;
  logic [CNT_W-1:0]     instret_q, instret_d;

  cls_e       dec_cls, cls;
  logic [2:0] dec_imm;
  logic       dec_asel, dec_bsel, dec_brun, dec_signed, dec_illegal;
  logic [3:0] dec_alu;
  logic [1:0] dec_size;
  logic       in_instr, timeout_hit, br_cond;

  mc_decode u_decode (
    .key_i     (operation_key),
    .cls_o     (dec_cls),
    .imm_sel_o (dec_imm),
    .a_sel_o   (dec_asel),
    .b_sel_o   (dec_bsel),
    .alu_sel_o (dec_alu),
    .br_un_o   (dec_brun),
    .size_o    (dec_size),
    .signed_o  (dec_signed),
    .illegal_o (dec_illegal)
  );

  // Illegal keys behave as NOP whenever they reach EXEC/WB.
  assign cls      = dec_illegal ? CLS_NOP : dec_cls;
  assign in_instr = (state_q == DECODE) || (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
  // Fires on the waiting cycle that brings the count up to MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    case (operation_key[7:5])
      3'b000:        br_cond = BrEq;
      3'b001:        br_cond = ~BrEq;
      3'b100, 3'b110: br_cond = BrLT;
      3'b101, 3'b111: br_cond = ~BrLT;
      default:       br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_cnt_q;
    taken_d   = taken_q;
    instret_d = instret_q;
    bus.imem_req          = 1'b0;
    bus.ir_write          = 1'b0;
    bus.dmem_req          = 1'b0;
    bus.mdr_write         = 1'b0;
    bus.MemRW             = 1'b0;
    bus.d_mem_access_size = SZ_W;
    bus.dmem_is_signed    = 1'b0;
    PCSel    = 1'b0;
    pc_write = 1'b0;
    ImmSel   = IMM_I;
    BrUn     = 1'b0;
    ASel     = 1'b0;
    BSel     = 1'b0;
    ALUSel   = ALU_ADD;
    RegWEn   = 1'b0;
    WBSel    = WB_ALU;
    retire   = 1'b0;

    if (in_instr) begin
      ImmSel = dec_imm;
      ASel   = dec_asel;
      BSel   = dec_bsel;
      ALUSel = dec_alu;
      BrUn   = dec_brun;
      WBSel  = wb_sel_of(cls);
      bus.d_mem_access_size = dec_size;
      bus.dmem_is_signed    = dec_signed;
    end

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_write = 1'b1;
          state_d      = DECODE;
        end else begin
          wait_d = wait_cnt_q + TIMEOUT_W'(1);
          if (timeout_hit) state_d = ERR;
        end
      end
      DECODE: begin
        state_d = EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (dec_illegal) state_d = TRAP;
`endif
      end
      EXEC: begin
        taken_d = (cls == CLS_BRANCH) && br_cond;
        if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = MEM;
          wait_d  = '0;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.MemRW    = (cls == CLS_STORE);
        if (bus.dmem_ack) begin
          bus.mdr_write = (cls == CLS_LOAD);
          state_d       = WB;
        end else begin
          wait_d = wait_cnt_q + TIMEOUT_W'(1);
          if (timeout_hit) state_d = ERR;
        end
      end
      WB: begin
        pc_write  = 1'b1;
        retire    = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        RegWEn    = writes_rd(cls);
        PCSel     = (cls == CLS_JAL) || (cls == CLS_JALR) || ((cls == CLS_BRANCH) && taken_q);
        state_d   = FETCH;
        wait_d    = '0;
      end
      default: ; // ERR and TRAP hold until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      wait_cnt_q <= '0;
      taken_q    <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_d;
      taken_q    <= taken_d;
      instret_q  <= instret_d;
    end
  end

  assign instret = instret_q;
  assign mem_err = (state_q == ERR);
  assign state   = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == TRAP);
`endif
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import control_pkg::*;

  localparam int CNT_W = 4;

  localparam logic [8:0] K_ADD  = 9'b0_000_01100;
  localparam logic [8:0] K_SW   = 9'b0_010_01000;
  localparam logic [8:0] K_LBU  = 9'b0_100_00000;
  localparam logic [8:0] K_BEQ  = 9'b0_000_11000;
  localparam logic [8:0] K_BGEU = 9'b0_111_11000;
  localparam logic [8:0] K_JAL  = 9'b0_000_11011;
  localparam logic [8:0] K_JALR = 9'b0_000_11001;
  localparam logic [8:0] K_FNC  = 9'b0_000_00011;
  localparam logic [8:0] K_ILL  = 9'b0_000_11111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]       operation_key = '0;
  logic             BrEq = 1'b0, BrLT = 1'b0;
  logic             PCSel, pc_write, BrUn, ASel, BSel, RegWEn, retire, mem_err;
  logic [2:0]       ImmSel, dut_state;
  logic [3:0]       ALUSel;
  logic [1:0]       WBSel;
  logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_instr;
`endif

  multicycle_control_if mif ();

  multicycle_control #(.CNT_W(CNT_W), .TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .operation_key (operation_key),
    .BrEq          (BrEq),
    .BrLT          (BrLT),
    .bus           (mif.master),
    .PCSel         (PCSel),
    .pc_write      (pc_write),
    .ImmSel        (ImmSel),
    .BrUn          (BrUn),
    .ASel          (ASel),
    .BSel          (BSel),
    .ALUSel        (ALUSel),
    .RegWEn        (RegWEn),
    .WBSel         (WBSel),
    .retire        (retire),
    .instret       (instret),
    .mem_err       (mem_err),
    .state         (dut_state)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  // scoreboard: {pc_write, PCSel, RegWEn, WBSel, instret before retire}
  logic [8:0]       exp_q[$];
  logic [CNT_W-1:0] exp_instret = '0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every retire pops one expected record
  always @(negedge clk) begin
    if (rst_n && retire) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got retire with empty queue, want none");
      end else begin
        check("retire_record", {pc_write, PCSel, RegWEn, WBSel, instret}, exp_q.pop_front());
      end
    end
  end

  // per-instruction observations collected by the driver
  int         obs_cycles, obs_fetch, obs_irw, obs_dreq, obs_memrw, obs_mdrw, obs_regwen_early;
  logic [2:0] obs_imm_dec, obs_imm_mem;
  logic [1:0] obs_size_mem;
  logic       obs_sgn_mem, obs_asel, obs_bsel, obs_brun;

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    exp_q.delete();
    exp_instret = '0;
    #1;
    check({tag, "_state"}, 32'(dut_state), 32'(BOOT));
    check({tag, "_instret"}, 32'(instret), 0);
    check({tag, "_wbsel"}, 32'(WBSel), 32'b01);
    check({tag, "_size"}, 32'(mif.d_mem_access_size), 32'b10);
    check({tag, "_others"}, 32'({PCSel, pc_write, ImmSel, BrUn, ASel, BSel, ALUSel, RegWEn, retire,
          mem_err, mif.imem_req, mif.ir_write, mif.dmem_req, mif.mdr_write, mif.MemRW,
          mif.dmem_is_signed}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one instruction from the current state (BOOT or FETCH) through WB.
  // fl/ml: number of waiting cycles before imem/dmem ack.
  task automatic run_instr(input logic [8:0] key, input int fl, input int ml, input logic eq,
                           input logic lt, input logic e_pcsel, input logic e_regwen,
                           input logic [1:0] e_wbsel);
    int fw = 0;
    int mw = 0;
    bit done = 1'b0;
    operation_key = key;
    BrEq = eq;
    BrLT = lt;
    exp_q.push_back({1'b1, e_pcsel, e_regwen, e_wbsel, exp_instret});
    exp_instret = exp_instret + 1'b1;
    obs_cycles = 0; obs_fetch = 0; obs_irw = 0; obs_dreq = 0; obs_memrw = 0; obs_mdrw = 0;
    obs_regwen_early = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      mif.imem_ack = (dut_state == FETCH) && (fw == fl);
      mif.dmem_ack = (dut_state == MEM) && (mw == ml);
      #1;
      obs_cycles++;
      if (dut_state != WB && RegWEn) obs_regwen_early++;
      case (dut_state)
        FETCH: begin obs_fetch++; fw++; obs_irw += int'(mif.ir_write); end
        DECODE: obs_imm_dec = ImmSel;
        EXEC: begin obs_asel = ASel; obs_bsel = BSel; obs_brun = BrUn; end
        MEM: begin
          mw++;
          obs_dreq  += int'(mif.dmem_req);
          obs_memrw += int'(mif.MemRW);
          obs_mdrw  += int'(mif.mdr_write);
          obs_imm_mem  = ImmSel;
          obs_size_mem = mif.d_mem_access_size;
          obs_sgn_mem  = mif.dmem_is_signed;
        end
        WB: done = 1'b1;
        default: ;
      endcase
      @(negedge clk);
    end
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL instr_budget: key %b got no WB within 40 cycles, want WB", key);
    end
  endtask

  initial begin
    mif.imem_ack = 1'b0;
    mif.dmem_ack = 1'b0;
    do_reset("rst0");

    // 1: ADD with 3 late fetch cycles, counted from BOOT
    run_instr(K_ADD, 3, 0, 0, 0, 1'b0, 1'b1, 2'b01);
    check("add_fetch_cycles", obs_fetch, 4);
    check("add_ir_write", obs_irw, 1);
    check("add_regwen_early", obs_regwen_early, 0);
    check("add_total_cycles", obs_cycles, 8);
    check("add_instret", 32'(instret), 1);

    // 2: SW with ack in the first FETCH cycle, dmem ack after 2 waits; then LBU
    run_instr(K_SW, 0, 2, 0, 0, 1'b0, 1'b0, 2'b01);
    check("sw_fetch_cycles", obs_fetch, 1);
    check("sw_dmem_req", obs_dreq, 3);
    check("sw_memrw", obs_memrw, 3);
    check("sw_size", 32'(obs_size_mem), 32'b10);
    check("sw_immsel", 32'(obs_imm_mem), 32'b100);
    check("sw_regwen_early", obs_regwen_early, 0);
    run_instr(K_LBU, 1, 1, 0, 0, 1'b0, 1'b1, 2'b00);
    check("lbu_mdr_write", obs_mdrw, 1);
    check("lbu_signed", 32'(obs_sgn_mem), 0);
    check("lbu_size", 32'(obs_size_mem), 32'b00);
    check("lbu_memrw", obs_memrw, 0);

    // 3: branches
    run_instr(K_BEQ, 0, 0, 1, 0, 1'b1, 1'b0, 2'b01);
    run_instr(K_BEQ, 0, 0, 0, 0, 1'b0, 1'b0, 2'b01);
    run_instr(K_BGEU, 0, 0, 0, 0, 1'b1, 1'b0, 2'b01);
    check("bgeu_brun", 32'(obs_brun), 1);

    // 4: jumps
    run_instr(K_JAL, 0, 0, 0, 0, 1'b1, 1'b1, 2'b10);
    check("jal_immsel", 32'(obs_imm_dec), 32'b011);
    check("jal_asel_bsel", 32'({obs_asel, obs_bsel}), 32'b11);
    run_instr(K_JALR, 0, 0, 0, 0, 1'b1, 1'b1, 2'b10);
    check("jalr_immsel", 32'(obs_imm_dec), 32'b000);
    check("jalr_asel", 32'(obs_asel), 0);

`ifndef ILLEGAL_TRAP_EN
    // 6 (default build): illegal key retires as NOP
    run_instr(K_ILL, 0, 0, 0, 0, 1'b0, 1'b0, 2'b01);
    check("ill_regwen_early", obs_regwen_early, 0);
    check("ill_instret", 32'(instret), 9);
`else
    check("pre_trap_instret", 32'(instret), 8);
`endif

    // 5: instret wraps after 16 retires with a 4-bit counter
    do_reset("rst1");
    for (int i = 0; i < 16; i++) run_instr(K_FNC, 0, 0, 0, 0, 1'b0, 1'b0, 2'b01);
    check("wrap_instret", 32'(instret), 0);

    // 5: dmem ack never comes -> ERR after 4 waiting cycles
    do_reset("rst2");
    begin
      int dreq = 0;
      operation_key = K_SW;
      for (int c = 0; c < 30 && dut_state != ERR; c++) begin
        mif.imem_ack = (dut_state == FETCH);
        #1;
        if (dut_state == MEM) dreq += int'(mif.dmem_req);
        @(negedge clk);
      end
      mif.imem_ack = 1'b0;
      check("to_state", 32'(dut_state), 32'(ERR));
      check("to_wait_cycles", dreq, 4);
      check("to_dmem_req", 32'(mif.dmem_req), 0);
      check("to_mem_err", 32'(mem_err), 1);
      // acks with no request pending must not move the FSM
      mif.imem_ack = 1'b1;
      mif.dmem_ack = 1'b1;
      repeat (5) @(negedge clk);
      check("err_sticky_state", 32'(dut_state), 32'(ERR));
      check("err_sticky_flag", 32'(mem_err), 1);
      check("err_no_enables", 32'({mif.imem_req, mif.dmem_req, mif.ir_write, mif.mdr_write, pc_write,
            RegWEn, retire}), 0);
    end
    do_reset("rst3");

    // 5: reset asserted while MEM is waiting drops dmem_req at once
    run_instr(K_ADD, 0, 0, 0, 0, 1'b0, 1'b1, 2'b01);
    begin
      int mcyc = 0;
      operation_key = K_SW;
      for (int c = 0; c < 20 && mcyc < 2; c++) begin
        mif.imem_ack = (dut_state == FETCH);
        #1;
        if (dut_state == MEM) mcyc++;
        if (mcyc < 2) @(negedge clk);
      end
      check("midmem_req_before", 32'(mif.dmem_req), 1);
      do_reset("midmem");
    end

`ifdef ILLEGAL_TRAP_EN
    // 6 (trap build): illegal key parks in TRAP without retiring
    begin
      operation_key = K_ILL;
      for (int c = 0; c < 20 && dut_state != TRAP; c++) begin
        mif.imem_ack = (dut_state == FETCH);
        @(negedge clk);
      end
      mif.imem_ack = 1'b0;
      repeat (4) @(negedge clk);
      check("trap_state", 32'(dut_state), 32'(TRAP));
      check("trap_flag", 32'(illegal_instr), 1);
      check("trap_instret", 32'(instret), 0);
      check("trap_no_pcwrite", 32'({pc_write, retire}), 0);
      do_reset("rst4");
      check("trap_flag_cleared", 32'(illegal_instr), 0);
    end
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1, "watchdog");
  end
endmodule
